if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and runs a req/ack handshake with instruction memory.
- Buffers one returned instruction when decode is stalled.
- Drives registered pc/inst into decode, inserting NOPs (32'h0) when no valid instruction is available.
- Accepts a redirect (new PC) for future branch/jump support.

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_inst_buf.sv | 30 +++
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam int unsigned IF_PC_STEP = 4;

  typedef enum logic [1:0] {
    IF_ST_IDLE  = 2'b00,
    IF_ST_FETCH = 2'b01,
    IF_ST_HOLD  = 2'b10
  } if_state_e;

  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
    return {a[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_inst_buf.sv
// One-entry holding buffer for an instruction returned while decode is stalled.
module if_inst_buf
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic [INST_W-1:0]      inst_i,
  input  logic [INST_ADDR_W-1:0] pc_i,
  output logic                   valid_o,
  output logic [INST_W-1:0]      inst_o,
  output logic [INST_ADDR_W-1:0] pc_o
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      valid_o <= 1'b0;
      inst_o  <= ZERO_WORD;
      pc_o    <= '0;
    end else if (clear) begin
      valid_o <= 1'b0;
    end else if (load) begin
      valid_o <= 1'b1;
      inst_o  <= inst_i;
      pc_o    <= pc_i;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack memory handshake, stall buffering, redirect.
// Performance counters are built only when IF_PERF_CNT_EN is defined.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = IF_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_ack_i,
  input  logic [31:0] rom_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q;
  logic        in_fetch, in_hold;
  logic        take_redirect, deliver_rom, park_rom, bubble, deliver_buf;
  logic        buf_valid;
  logic [31:0] buf_inst, buf_pc;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= IF_ST_IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = IF_ST_IDLE;
    unique case (state_q)
      IF_ST_IDLE:  state_d = IF_ST_FETCH;
      IF_ST_FETCH: state_d = (!redirect_i && rom_ack_i && stall_i) ? IF_ST_HOLD : IF_ST_FETCH;
      IF_ST_HOLD:  state_d = (redirect_i || !stall_i) ? IF_ST_FETCH : IF_ST_HOLD;
      default:     state_d = IF_ST_IDLE;
    endcase
  end

  // Priority of the fetch/hold rules is folded into mutually exclusive strobes.
  always_comb begin
    in_fetch      = (state_q == IF_ST_FETCH);
    in_hold       = (state_q == IF_ST_HOLD);
    rom_req_o     = in_fetch;
    take_redirect = (in_fetch || in_hold) && redirect_i;
    deliver_rom   = in_fetch && !redirect_i && rom_ack_i && !stall_i;
    park_rom      = in_fetch && !redirect_i && rom_ack_i && stall_i;
    bubble        = in_fetch && !redirect_i && !rom_ack_i && !stall_i;
    deliver_buf   = in_hold && !redirect_i && !stall_i;
  end

  assign rom_addr_o = pc_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc_q      <= word_align(RESET_PC);
      id_pc_o   <= ZERO_WORD;
      id_inst_o <= ZERO_WORD;
    end else if (take_redirect) begin
      pc_q      <= word_align(redirect_pc_i);
      id_pc_o   <= ZERO_WORD;
      id_inst_o <= ZERO_WORD;
    end else if (deliver_rom) begin
      id_inst_o <= rom_data_i;
      id_pc_o   <= pc_q;
      pc_q      <= pc_q + STEP;
    end else if (park_rom) begin
      pc_q      <= pc_q + STEP;
    end else if (bubble) begin
      id_inst_o <= ZERO_WORD;
      id_pc_o   <= pc_q;
    end else if (deliver_buf) begin
      id_inst_o <= buf_valid ? buf_inst : ZERO_WORD;
      id_pc_o   <= buf_pc;
    end
  end

  if_inst_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (park_rom),
    .clear   (take_redirect || deliver_buf),
    .inst_i  (rom_data_i),
    .pc_i    (pc_q),
    .valid_o (buf_valid),
    .inst_o  (buf_inst),
    .pc_o    (buf_pc)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if ((deliver_rom || deliver_buf) && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bubble && bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign fetch_cnt_o  = ZERO_WORD;
  assign bubble_cnt_o = ZERO_WORD;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a cycle model predicts the post-edge outputs.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0, redirect_i = 1'b0, rom_ack_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        rom_req_o;
  logic [31:0] rom_addr_o, rom_data_i, id_pc_o, id_inst_o, fetch_cnt_o, bubble_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic        req;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;
  exp_t sb[$];

  // Model state
  int          m_st;  // 0 idle, 1 fetch, 2 hold
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_buf, m_buf_pc, m_fc, m_bc;

  if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
    .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic ack, input logic st,
                            input logic rd, input logic [31:0] rpc);
    exp_t e;
    if (r) begin
      m_st = 0; m_pc = 32'h0; m_id_pc = 0; m_id_inst = 0; m_fc = 0; m_bc = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (rd) begin
        m_pc = rpc & 32'hFFFF_FFFC; m_id_pc = 0; m_id_inst = 0;
      end else if (ack && !st) begin
        m_id_inst = rom_word(m_pc); m_id_pc = m_pc; m_pc = m_pc + 4; m_fc++;
      end else if (ack) begin
        m_buf = rom_word(m_pc); m_buf_pc = m_pc; m_pc = m_pc + 4; m_st = 2;
      end else if (!st) begin
        m_id_inst = 0; m_id_pc = m_pc; m_bc++;
      end
    end else begin
      if (rd) begin
        m_pc = rpc & 32'hFFFF_FFFC; m_id_pc = 0; m_id_inst = 0; m_st = 1;
      end else if (!st) begin
        m_id_inst = m_buf; m_id_pc = m_buf_pc; m_fc++; m_st = 1;
      end
    end
    e.addr = m_pc; e.req = (m_st == 1); e.pc = m_id_pc; e.inst = m_id_inst;
`ifdef IF_PERF_CNT_EN
    e.fc = m_fc; e.bc = m_bc;
`else
    e.fc = 0; e.bc = 0;
`endif
    sb.push_back(e);
  endtask

  // Drive inputs after the falling edge, predict at the rising edge, compare 1 ns later.
  task automatic cycle(input logic r, input logic ack, input logic st,
                       input logic rd, input logic [31:0] rpc);
    exp_t e;
    rst = r; rom_ack_i = ack; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    @(posedge clk);
    model_edge(r, ack, st, rd, rpc);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("rom_addr", rom_addr_o, e.addr);
      check("rom_req", {31'd0, rom_req_o}, {31'd0, e.req});
      check("id_pc", id_pc_o, e.pc);
      check("id_inst", id_inst_o, e.inst);
      check("fetch_cnt", fetch_cnt_o, e.fc);
      check("bubble_cnt", bubble_cnt_o, e.bc);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_req", {31'd0, rom_req_o}, 32'd0);
    check("rst_inst", id_inst_o, 32'd0);

    // Sequential fetch from reset, then two wait states at address 8
    cycle(0, 1, 0, 0, 0);
    check("first_addr", rom_addr_o, 32'h0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("seq_pc4", id_pc_o, 32'h4);
    check("seq_addr8", rom_addr_o, 32'h8);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("bubble_pc", id_pc_o, 32'h8);
    check("bubble_inst", id_inst_o, 32'h0);
    cycle(0, 1, 0, 0, 0);
    check("after_wait", id_inst_o, rom_word(32'h8));

    // Stall on an ack, held three cycles, then release
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    check("hold_req", {31'd0, rom_req_o}, 32'd0);
    check("hold_inst", id_inst_o, rom_word(32'h8));
    cycle(0, 0, 0, 0, 0);
    check("release_pc", id_pc_o, 32'hC);
    check("release_addr", rom_addr_o, 32'h10);

    // Redirect with ack and stall both high
    cycle(0, 1, 1, 1, 32'h0000_0103);
    check("redir_addr", rom_addr_o, 32'h100);
    check("redir_inst", id_inst_o, 32'h0);

    // Redirect near the top of the address space and wrap
    cycle(0, 1, 0, 1, 32'hFFFF_FFF8);
    cycle(0, 1, 0, 0, 0);
    check("wrap_addr1", rom_addr_o, 32'hFFFF_FFFC);
    cycle(0, 1, 0, 0, 0);
    check("wrap_addr2", rom_addr_o, 32'h0);
    check("wrap_pc", id_pc_o, 32'hFFFF_FFFC);

    // Redirect while in HOLD
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 32'h0000_0200);
    check("hold_redir_addr", rom_addr_o, 32'h200);
    check("hold_redir_req", {31'd0, rom_req_o}, 32'd1);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0), $urandom);
    end

    // Reset while in HOLD
    cycle(0, 0, 0, 1, 32'h40);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    check("rst_hold_req", {31'd0, rom_req_o}, 32'd0);
    check("rst_hold_cnt", fetch_cnt_o, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("rst_hold_addr", rom_addr_o, 32'h0);

    // Reset during a wait state
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_wait_inst", id_inst_o, 32'd0);
    check("rst_wait_bcnt", bubble_cnt_o, 32'd0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("rst_wait_first", id_inst_o, rom_word(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
